// File: rtl/onewire_pkg.sv
// Shared encodings and default bus timing (in clk cycles) for the single-wire master.
package onewire_pkg;

  typedef enum logic [1:0] {
    OP_RST  = 2'b00,
    OP_WBIT = 2'b01,
    OP_RBIT = 2'b10,
    OP_BYTE = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    RST_LOW,
    RST_REL,
    SLOT_LOW,
    SLOT_REL,
    RECOVER,
    RESP
  } state_t;

  localparam int unsigned DEF_T_RST    = 480;
  localparam int unsigned DEF_T_PDET   = 70;
  localparam int unsigned DEF_T_SLOT   = 60;
  localparam int unsigned DEF_T_LOW1   = 6;
  localparam int unsigned DEF_T_LOW0   = 55;
  localparam int unsigned DEF_T_SAMPLE = 14;
  localparam int unsigned DEF_T_REC    = 2;

endpackage

// File: rtl/onewire_sync.sv
// Two-flop synchronizer for the bus pin; resets to 1 so a released, pulled-up line reads idle.
module onewire_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // NOTE: flops are written with non-blocking assignments so each stage samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/onewire_master.sv
// Open-drain single-wire bus master: reset/presence and bit slots, one response per command.
// Define ONEWIRE_BYTE_EN to turn op 11 into an 8-slot LSB-first byte transfer; otherwise op 11 is illegal.
module onewire_master
  import onewire_pkg::*;
#(
  parameter int unsigned T_RST    = DEF_T_RST,
  parameter int unsigned T_PDET   = DEF_T_PDET,
  parameter int unsigned T_SLOT   = DEF_T_SLOT,
  parameter int unsigned T_LOW1   = DEF_T_LOW1,
  parameter int unsigned T_LOW0   = DEF_T_LOW0,
  parameter int unsigned T_SAMPLE = DEF_T_SAMPLE,
  parameter int unsigned T_REC    = DEF_T_REC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_presence,
  output logic       rsp_err,
  inout  wire        line
);

  localparam int unsigned CNT_W = $clog2(2 * T_RST + 1);

  localparam logic [CNT_W-1:0] C_RST_END  = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] C_PDET     = CNT_W'(T_PDET);
  localparam logic [CNT_W-1:0] C_SLOT_END = CNT_W'(T_SLOT - 1);
  localparam logic [CNT_W-1:0] C_SAMPLE   = CNT_W'(T_SAMPLE);
  localparam logic [CNT_W-1:0] C_LOW0     = CNT_W'(T_LOW0);
  localparam logic [CNT_W-1:0] C_LOW1     = CNT_W'(T_LOW1);
  localparam logic [CNT_W-1:0] C_REC_END  = CNT_W'(T_REC - 1);

`ifdef ONEWIRE_BYTE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  if (!(T_LOW1 < T_SAMPLE && T_SAMPLE < T_LOW0 && T_LOW0 < T_SLOT &&
        T_PDET < T_RST && T_REC >= 1)) begin : g_bad_timing
    $error("onewire_master: illegal timing parameter set");
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  op_t              r_op;
  logic [7:0]       r_data;
  logic             r_err;
  logic             r_sample;
  logic             r_presence;

  logic             w_sync;
  logic             w_oe;
  logic             w_cur_bit;
  logic             w_last_bit;
  logic [CNT_W-1:0] w_low_len;
  logic [CNT_W-1:0] w_slot_cyc;
  logic             w_sample_now;
  logic             w_pdet_now;
  logic             w_presence;
  logic             w_rsp_load;
  logic [7:0]       w_byte_shift;
  logic [7:0]       w_rsp_byte;

  onewire_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (line),
    .o_q   (w_sync)
  );

  assign line = w_oe ? 1'b0 : 1'bz;

  // The counter restarts on each state entry, so in SLOT_REL the slot cycle is offset by the low time.
  assign w_low_len    = (r_op != OP_RBIT && !w_cur_bit) ? C_LOW0 : C_LOW1;
  assign w_slot_cyc   = (r_state == SLOT_REL) ? (w_low_len + r_cnt) : r_cnt;
  assign w_sample_now = ((r_state == SLOT_LOW) || (r_state == SLOT_REL)) && (w_slot_cyc == C_SAMPLE);
  assign w_pdet_now   = (r_state == RST_REL) && (r_cnt == C_PDET);
  assign w_presence   = w_pdet_now ? ~w_sync : r_presence;
  assign w_rsp_load   = (w_state_next == RESP);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the case infers a latch.
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    w_oe         = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid) begin
          case (op_t'(cmd_op))
            OP_RST:           w_state_next = RST_LOW;
            OP_WBIT, OP_RBIT: w_state_next = SLOT_LOW;
            default:          w_state_next = BYTE_EN ? SLOT_LOW : RECOVER;
          endcase
        end
      end
      RST_LOW: begin
        w_oe = 1'b1;
        if (r_cnt == C_RST_END) w_state_next = RST_REL;
      end
      RST_REL: begin
        if (r_cnt == C_RST_END) w_state_next = RESP;
      end
      SLOT_LOW: begin
        w_oe = 1'b1;
        if (r_cnt == w_low_len - 1'b1) w_state_next = SLOT_REL;
      end
      SLOT_REL: begin
        if (w_slot_cyc == C_SLOT_END) w_state_next = RECOVER;
      end
      RECOVER: begin
        // An illegal op parks here for a single released cycle before responding.
        if (r_err || r_cnt == C_REC_END) w_state_next = w_last_bit ? RESP : SLOT_LOW;
      end
      RESP: begin
        rsp_valid    = rst_n;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_rsp_byte = 8'h00;
    if (!r_err && r_op != OP_RST) begin
      w_rsp_byte = (r_op == OP_BYTE) ? w_byte_shift : {7'b0, r_sample};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_op         <= OP_RST;
      r_data       <= 8'h00;
      r_err        <= 1'b0;
      r_sample     <= 1'b1;
      r_presence   <= 1'b0;
      rsp_data     <= 8'h00;
      rsp_presence <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_state_next != r_state || r_state == IDLE) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == IDLE && cmd_valid) begin
        r_op   <= op_t'(cmd_op);
        r_data <= cmd_data;
        r_err  <= (op_t'(cmd_op) == OP_BYTE) && !BYTE_EN;
      end

      if (w_sample_now) r_sample <= w_sync;
      if (w_pdet_now)   r_presence <= ~w_sync;

      if (w_rsp_load) begin
        rsp_err      <= r_err;
        rsp_presence <= (r_op == OP_RST) && w_presence;
        rsp_data     <= w_rsp_byte;
      end
    end
  end

`ifdef ONEWIRE_BYTE_EN
  logic [2:0] r_bit_idx;
  logic [7:0] r_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      if (r_state == IDLE) begin
        r_bit_idx <= 3'd0;
      end else if (r_state == RECOVER && w_state_next == SLOT_LOW) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end
      // Shifting in at the MSB leaves the first (LSB) slot in bit 0 after eight slots.
      if (w_sample_now) r_shift <= {w_sync, r_shift[7:1]};
    end
  end

  assign w_cur_bit    = r_data[r_bit_idx];
  assign w_last_bit   = (r_op != OP_BYTE) || (r_bit_idx == 3'd7);
  assign w_byte_shift = r_shift;
`else
  logic w_unused_data;

  assign w_unused_data = ^r_data[7:1];
  assign w_cur_bit     = r_data[0];
  assign w_last_bit    = 1'b1;
  assign w_byte_shift  = 8'h00;
`endif

endmodule

// File: tb/tb_onewire_master.sv
// Bench for onewire_master: pulled-up line, 3-cycle wire delay each way, scripted slave, vector table.
module tb_onewire_master;
  import onewire_pkg::*;

  typedef enum logic [1:0] {SL_NONE, SL_PRES, SL_READ0, SL_BYTE} slave_e;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    slave_e     slave;
    int         lat;
    int         low;
    logic [7:0] rdata;
    logic       pres;
    logic       err;
  } vec_t;

  localparam int N_VEC = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_presence;
  logic       rsp_err;
  wire        line;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  onewire_master dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_presence (rsp_presence),
    .rsp_err      (rsp_err),
    .line         (line)
  );

  // Wire-delay model: side A is the master pin, side B is the slave's view.
  logic [2:0] a2b_pipe = 3'b000;
  logic [2:0] b2a_pipe = 3'b000;
  logic       b_prev   = 1'b0;
  int         fall_cnt = 1000;
  int         rise_cnt = 1000;
  int         fall_total = 0;
  int         byte_base  = 0;
  logic [7:0] slave_pat  = 8'h3C;
  logic [7:0] slave_wr   = 8'hA5;
  slave_e     slave_mode = SL_NONE;
  logic       slave_drv_b;
  logic [2:0] slave_k;
  wire        master_low;

  pullup (line);
  assign line       = b2a_pipe[2] ? 1'b0 : 1'bz;
  assign master_low = (line == 1'b0) && !b2a_pipe[2];

  always @(posedge clk) begin
    a2b_pipe <= {a2b_pipe[1:0], master_low};
    b2a_pipe <= {b2a_pipe[1:0], slave_drv_b};
    b_prev   <= a2b_pipe[2];
    if (a2b_pipe[2] && !b_prev) begin
      fall_cnt   <= 0;
      fall_total <= fall_total + 1;
    end else if (fall_cnt < 1000) begin
      fall_cnt <= fall_cnt + 1;
    end
    if (!a2b_pipe[2] && b_prev) rise_cnt <= 0;
    else if (rise_cnt < 1000) rise_cnt <= rise_cnt + 1;
  end

  always_comb begin
    slave_k     = 3'(fall_total - byte_base - 1);
    slave_drv_b = 1'b0;
    case (slave_mode)
      SL_PRES:  slave_drv_b = (rise_cnt >= 20) && (rise_cnt <= 140);
      SL_READ0: slave_drv_b = (fall_cnt >= 1) && (fall_cnt <= 30);
      SL_BYTE:  slave_drv_b = (fall_cnt >= 1) && (fall_cnt <= 30) &&
                              slave_wr[slave_k] && !slave_pat[slave_k];
      default:  slave_drv_b = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("issue_ready", 32'(cmd_ready), 32'd1);
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
  endtask

  vec_t vecs [N_VEC];

  initial begin
    int lat;
    int low;
    int seen;

    vecs[0] = '{2'b00, 8'h00, SL_PRES,  961, 480, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{2'b00, 8'h00, SL_NONE,  961, 480, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{2'b01, 8'h00, SL_NONE,   63,  55, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{2'b01, 8'h01, SL_NONE,   63,   6, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{2'b01, 8'hFE, SL_NONE,   63,  55, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 8'h00, SL_READ0,  63,   6, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{2'b10, 8'h00, SL_NONE,   63,   6, 8'h01, 1'b0, 1'b0};
`ifdef ONEWIRE_BYTE_EN
    vecs[7] = '{2'b11, 8'hA5, SL_BYTE,  497, 244, 8'h24, 1'b0, 1'b0};
`else
    vecs[7] = '{2'b11, 8'hFF, SL_NONE,    2,   0, 8'h00, 1'b0, 1'b1};
`endif

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_presence", 32'(rsp_presence), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_line_released", 32'(line), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < N_VEC; i++) begin
      slave_mode = vecs[i].slave;
      byte_base  = fall_total;
      issue(vecs[i].op, vecs[i].data);
      lat = -1;
      low = 0;
      for (int n = 1; n <= 1200; n++) begin
        @(negedge clk);
        if (n == 1) check($sformatf("v%0d_busy", i), 32'(cmd_ready), 32'd0);
        if (master_low) low++;
        if (rsp_valid) begin
          lat = n;
          break;
        end
      end
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_low_cycles", i), 32'(low), 32'(vecs[i].low));
      check($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].rdata));
      check($sformatf("v%0d_presence", i), 32'(rsp_presence), 32'(vecs[i].pres));
      check($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vecs[i].err));
      check($sformatf("v%0d_ready_on_rsp", i), 32'(cmd_ready), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_rsp_one_cycle", i), 32'(rsp_valid), 32'd0);
      check($sformatf("v%0d_rsp_data_hold", i), 32'(rsp_data), 32'(vecs[i].rdata));
      slave_mode = SL_NONE;
      repeat (5) @(negedge clk);
    end

    // Reset in the middle of a write-0 slot: line released at once, no response afterwards.
    issue(2'b01, 8'h00);
    repeat (31) @(negedge clk);
    check("midrst_line_low_before", 32'(master_low), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_line_released", 32'(line), 32'd1);
    check("midrst_ready_in_reset", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", 32'(cmd_ready), 32'd1);
    check("midrst_err_cleared", 32'(rsp_err), 32'd0);
    check("midrst_data_cleared", 32'(rsp_data), 32'd0);
    seen = 0;
    low  = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
      if (master_low) low++;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    check("midrst_line_idle", 32'(low), 32'd0);

    // The master must come back fully usable after the aborted slot.
    issue(2'b01, 8'h01);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
    check("recover_latency", 32'(lat), 32'd63);
    check("recover_rsp_data", 32'(rsp_data), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
